// File: rtl/regfile_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter_if
// Description : Bundle of the requester handshake, the clear-start pulse and
//               the register-file write-port signals of regfile_wr_arbiter.
//               Parameters W (data width) and N (requester count) must match
//               the arbiter instance.
//               Optional macro REGFILE_R15_LOCK_EN adds the DROP signal.
// Signals     : REQ_VALID[N]  requester i presents a write
//               REQ_ADDR[4N]  requester i address, bits [4i+3:4i]
//               REQ_DATA[WN]  requester i data, bits [Wi+W-1:Wi]
//               REQ_READY[N]  requester i accepted this cycle
//               CLR_START     single-cycle pulse starting the clear sweep
//               WEN/WADDR/WDATA  registered register-file write port
//               GNT_ID        requester that produced the current write
//               BUSY          clear sweep running
//               DROP          (REGFILE_R15_LOCK_EN only) address-15 write dropped
// Modports    : slave  - arbiter view
//               master - requester / register-file side view
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wr_arbiter_if #(
  parameter int W = 32,
  parameter int N = 3
);
  logic [N-1:0]   REQ_VALID;
  logic [4*N-1:0] REQ_ADDR;
  logic [W*N-1:0] REQ_DATA;
  logic [N-1:0]   REQ_READY;
  logic           CLR_START;
  logic           WEN;
  logic [3:0]     WADDR;
  logic [W-1:0]   WDATA;
  logic [2:0]     GNT_ID;
  logic           BUSY;
`ifdef REGFILE_R15_LOCK_EN
  logic           DROP;

  modport slave (
    input  REQ_VALID, REQ_ADDR, REQ_DATA, CLR_START,
    output REQ_READY, WEN, WADDR, WDATA, GNT_ID, BUSY, DROP
  );

  modport master (
    output REQ_VALID, REQ_ADDR, REQ_DATA, CLR_START,
    input  REQ_READY, WEN, WADDR, WDATA, GNT_ID, BUSY, DROP
  );
`else
  modport slave (
    input  REQ_VALID, REQ_ADDR, REQ_DATA, CLR_START,
    output REQ_READY, WEN, WADDR, WDATA, GNT_ID, BUSY
  );

  modport master (
    output REQ_VALID, REQ_ADDR, REQ_DATA, CLR_START,
    input  REQ_READY, WEN, WADDR, WDATA, GNT_ID, BUSY
  );
`endif
endinterface
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Round-robin arbiter sharing the single write port of a
//               16-entry W-bit register file among N requesters, plus a
//               clear sequencer that writes zero to addresses 0..15 over
//               16 consecutive cycles. Write-port outputs are registered;
//               REQ_READY is combinational.
// Parameters  : W - data width (default 32)
//               N - number of requesters, 2..8 (default 3)
// Ports       : CLK  - rising-edge clock
//               RES  - asynchronous active-low reset
//               bus  - regfile_wr_arbiter_if.slave (handshake + write port)
// Option      : define REGFILE_R15_LOCK_EN to drop requester writes to
//               address 15 (handshake completes, DROP pulses instead of WEN)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter #(
  parameter int W = 32,
  parameter int N = 3
) (
  input  wire logic             CLK,
  input  wire logic             RES,
  regfile_wr_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t         r_state;
  logic [2:0]     r_rr_ptr;
  logic [3:0]     r_clr_cnt;
  logic           r_wen;
  logic [3:0]     r_waddr;
  logic [W-1:0]   r_wdata;
  logic [2:0]     r_gnt_id;
`ifdef REGFILE_R15_LOCK_EN
  logic           r_drop;
`endif

  logic           w_found;
  logic [2:0]     w_winner;
  logic           w_arb_ok;
  logic [N-1:0]   w_ready;
  logic [3:0]     w_sel_addr;
  logic [W-1:0]   w_sel_data;

  // Rotating priority search starting at r_rr_ptr. The loop runs from the
  // farthest offset down to offset 0 so the closest valid requester is the
  // last assignment and therefore wins.
  always_comb begin : p_pick
    logic [3:0] v_idx;
    v_idx    = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = N - 1; k >= 0; k--) begin
      v_idx = 4'(r_rr_ptr) + 4'(k);
      if (v_idx >= 4'(N)) begin
        v_idx = v_idx - 4'(N);
      end
      for (int i = 0; i < N; i++) begin
        if ((v_idx == 4'(i)) && bus.REQ_VALID[i]) begin
          w_found  = 1'b1;
          w_winner = 3'(i);
        end
      end
    end
  end

  always_comb begin : p_select
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_winner == 3'(i)) begin
        w_sel_addr = bus.REQ_ADDR[4*i +: 4];
        w_sel_data = bus.REQ_DATA[W*i +: W];
      end
    end
  end

  // A clear request in the same cycle wins over any pending write, and
  // nothing is granted while reset is asserted.
  assign w_arb_ok = RES && (r_state == ST_ARB) && !bus.CLR_START && w_found;

  always_comb begin : p_ready
    w_ready = '0;
    for (int i = 0; i < N; i++) begin
      w_ready[i] = w_arb_ok && (w_winner == 3'(i));
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_state   <= ST_ARB;
      r_rr_ptr  <= '0;
      r_clr_cnt <= '0;
      r_wen     <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_gnt_id  <= '0;
`ifdef REGFILE_R15_LOCK_EN
      r_drop    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_ARB: begin
          r_wen  <= 1'b0;
`ifdef REGFILE_R15_LOCK_EN
          r_drop <= 1'b0;
`endif
          if (bus.CLR_START) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
          end else if (w_found) begin
            r_rr_ptr <= (w_winner == 3'(N - 1)) ? 3'd0 : (w_winner + 3'd1);
`ifdef REGFILE_R15_LOCK_EN
            // Accepted but discarded; address/data/grant keep their last values.
            if (w_sel_addr == 4'hF) begin
              r_drop <= 1'b1;
            end else begin
              r_wen    <= 1'b1;
              r_waddr  <= w_sel_addr;
              r_wdata  <= w_sel_data;
              r_gnt_id <= w_winner;
            end
`else
            r_wen    <= 1'b1;
            r_waddr  <= w_sel_addr;
            r_wdata  <= w_sel_data;
            r_gnt_id <= w_winner;
`endif
          end
        end
        ST_CLEAR: begin
          // The counter wraps 15 -> 0 on the last issue, ready for the next sweep.
          r_wen     <= 1'b1;
          r_waddr   <= r_clr_cnt;
          r_wdata   <= '0;
          r_clr_cnt <= r_clr_cnt + 4'd1;
`ifdef REGFILE_R15_LOCK_EN
          r_drop    <= 1'b0;
`endif
          if (r_clr_cnt == 4'hF) begin
            r_state <= ST_ARB;
          end
        end
        default: begin
          r_state <= ST_ARB;
        end
      endcase
    end
  end

  assign bus.REQ_READY = w_ready;
  assign bus.WEN       = r_wen;
  assign bus.WADDR     = r_waddr;
  assign bus.WDATA     = r_wdata;
  assign bus.GNT_ID    = r_gnt_id;
  assign bus.BUSY      = (r_state == ST_CLEAR);
`ifdef REGFILE_R15_LOCK_EN
  assign bus.DROP      = r_drop;
`endif

endmodule
`default_nettype wire
